// File: rtl/decode_pkg.sv
// Shared constants, field positions and the ID_EX bundle type for the decode stage.
package decode_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned NREGS   = 32;
   localparam int unsigned ID_EX_W = 181;
   localparam int unsigned IF_ID_W = 64;

   // IF_ID field positions
   localparam int unsigned IFID_PC_LSB    = 32;
   localparam int unsigned IFID_INSTR_LSB = 0;

   // ID_EX field positions
   localparam int unsigned IDEX_VALID     = 180;
   localparam int unsigned IDEX_REG_WRITE = 179;
   localparam int unsigned IDEX_ALU_LSB   = 175;
   localparam int unsigned IDEX_RD_LSB    = 170;
   localparam int unsigned IDEX_RT_LSB    = 165;
   localparam int unsigned IDEX_RS_LSB    = 160;
   localparam int unsigned IDEX_INSTR_LSB = 128;
   localparam int unsigned IDEX_PC_LSB    = 96;
   localparam int unsigned IDEX_RSV_LSB   = 64;
   localparam int unsigned IDEX_RTV_LSB   = 32;
   localparam int unsigned IDEX_IMM_LSB   = 0;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [3:0] {
      ALU_ADD     = 4'd0,
      ALU_SUB     = 4'd1,
      ALU_AND     = 4'd2,
      ALU_OR      = 4'd3,
      ALU_SLT     = 4'd4,
      ALU_ILLEGAL = 4'hF
   } alu_op_e;

   // Field order matches the ID_EX bit layout, MSB first
   typedef struct packed {
      logic            valid;
      logic            reg_write;
      alu_op_e         alu_op;
      logic [4:0]      rd;
      logic [4:0]      rt;
      logic [4:0]      rs;
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs_val;
      logic [XLEN-1:0] rt_val;
      logic [XLEN-1:0] imm;
   } id_ex_t;

   function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
      return {{(XLEN-16){v[15]}}, v};
   endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// id_regfile: 32x32 register file, two read ports with write-through bypass, one write port,
// r0 hardwired to zero, asynchronously cleared.
module id_regfile
   import decode_pkg::*;
#(
   parameter int unsigned NREGS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ra0,
   input  logic [4:0]  ra1,
   output logic [31:0] rd0,
   output logic [31:0] rd1,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd
);

   logic [31:0] regs_q [NREGS];
   logic [31:0] regs_d [NREGS];

   always_comb begin
      regs_d = regs_q;
      if (we && (wa != '0)) begin
         regs_d[wa] = wd;
      end
   end

   // Reading the next-state array gives the same-cycle write-through for free
   always_comb begin
      rd0 = (ra0 == '0) ? '0 : regs_d[ra0];
      rd1 = (ra1 == '0) ? '0 : regs_d[ra1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: field decode, operand read, write-back and registered ID_EX bundle.
// Build option: define DECODE_HAZARD_EN to stall one cycle on a load-use dependency.
module decode_stage
   import decode_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           if_valid,
   input  logic [63:0]    IF_ID,
   output logic           id_ready,
   input  logic           wb_we,
   input  logic [4:0]     wb_addr,
   input  logic [31:0]    wb_data,
   output logic [180:0]   ID_EX
);

   logic [31:0] instr;
   logic [31:0] pc;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd_field;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        hazard;
   id_ex_t      dec;
   id_ex_t      id_ex_d;
   id_ex_t      id_ex_q;

   always_comb begin
      instr    = IF_ID[IFID_INSTR_LSB +: 32];
      pc       = IF_ID[IFID_PC_LSB +: 32];
      opcode   = instr[31:26];
      rs       = instr[25:21];
      rt       = instr[20:16];
      rd_field = instr[15:11];
      funct    = instr[5:0];
   end

   id_regfile #(
      .NREGS (NREGS)
   ) u_regfile (
      .clk (clock),
      .rst (reset),
      .ra0 (rs),
      .ra1 (rt),
      .rd0 (rs_val),
      .rd1 (rt_val),
      .we  (wb_we),
      .wa  (wb_addr),
      .wd  (wb_data)
   );

   always_comb begin
      dec           = '0;
      dec.valid     = 1'b1;
      dec.instr     = instr;
      dec.pc        = pc;
      dec.rs        = rs;
      dec.rt        = rt;
      dec.rs_val    = rs_val;
      dec.rt_val    = rt_val;
      dec.imm       = sext16(instr[15:0]);
      dec.alu_op    = ALU_ILLEGAL;
      dec.reg_write = 1'b0;
      dec.rd        = '0;
      case (opcode)
         OP_RTYPE: begin
            dec.reg_write = 1'b1;
            dec.rd        = rd_field;
            case (funct)
               FN_ADD:  dec.alu_op = ALU_ADD;
               FN_SUB:  dec.alu_op = ALU_SUB;
               FN_AND:  dec.alu_op = ALU_AND;
               FN_OR:   dec.alu_op = ALU_OR;
               FN_SLT:  dec.alu_op = ALU_SLT;
               default: begin
                  dec.alu_op    = ALU_ILLEGAL;
                  dec.reg_write = 1'b0;
                  dec.rd        = '0;
               end
            endcase
         end
         OP_ADDI, OP_LW: begin
            dec.alu_op    = ALU_ADD;
            dec.reg_write = 1'b1;
            dec.rd        = rt;
         end
         OP_SW:   dec.alu_op = ALU_ADD;
         OP_BEQ:  dec.alu_op = ALU_SUB;
         default: dec.alu_op = ALU_ILLEGAL;
      endcase
      if (dec.rd == '0) begin
         dec.reg_write = 1'b0;
      end
   end

`ifdef DECODE_HAZARD_EN
   logic uses_rt;

   // rt is only a source for R-type, SW and BEQ; for ADDI/LW it is the destination
   always_comb begin
      uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
      hazard  = id_ex_q.valid
             && (id_ex_q.instr[31:26] == OP_LW)
             && (id_ex_q.rd != '0)
             && ((id_ex_q.rd == rs) || ((id_ex_q.rd == rt) && uses_rt));
   end
`else
   always_comb begin
      hazard = 1'b0;
   end
`endif

   always_comb begin
      id_ready = !reset && !hazard;
      id_ex_d  = (if_valid && id_ready) ? dec : '0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         id_ex_q <= '0;
      end else begin
         id_ex_q <= id_ex_d;
      end
   end

   assign ID_EX = id_ex_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors push expected ID_EX values, a negedge monitor compares.
module tb_decode_stage;

   logic         clock;
   logic         reset;
   logic         if_valid;
   logic [63:0]  IF_ID;
   logic         id_ready;
   logic         wb_we;
   logic [4:0]   wb_addr;
   logic [31:0]  wb_data;
   logic [180:0] ID_EX;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned cyc      = 0;

   typedef struct {
      int unsigned  cyc;
      logic [180:0] val;
      string        name;
   } exp_t;

   exp_t q[$];
   exp_t e;

   decode_stage dut (
      .clock    (clock),
      .reset    (reset),
      .if_valid (if_valid),
      .IF_ID    (IF_ID),
      .id_ready (id_ready),
      .wb_we    (wb_we),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .ID_EX    (ID_EX)
   );

   initial begin
      clock = 1'b1;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         checks++;
         if (e.cyc != cyc || ID_EX !== e.val) begin
            failures++;
            $display("FAIL %s: ID_EX=%h expected %h (cycle %0d, due %0d)", e.name, ID_EX, e.val, cyc, e.cyc);
         end
      end
   end

   function automatic logic [180:0] mk(input logic v, input logic rw, input logic [3:0] alu,
                                       input logic [4:0] rd, input logic [4:0] rt, input logic [4:0] rs,
                                       input logic [31:0] instr, input logic [31:0] pc,
                                       input logic [31:0] rsv, input logic [31:0] rtv,
                                       input logic [31:0] imm);
      return {v, rw, alu, rd, rt, rs, instr, pc, rsv, rtv, imm};
   endfunction

   task automatic chk(input string nm, input logic [180:0] got, input logic [180:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
      if_valid = v;
      IF_ID    = {pc, instr};
      wb_we    = we;
      wb_addr  = wa;
      wb_data  = wd;
   endtask

   task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [180:0] exp, input string nm);
      exp_t x;
      drive(v, pc, instr, we, wa, wd);
      x.cyc  = cyc + 1;
      x.val  = exp;
      x.name = nm;
      q.push_back(x);
      @(posedge clock);
      #1;
   endtask

   localparam logic [180:0] BUBBLE = '0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
      #12;
      chk("reset_id_ex", ID_EX, BUBBLE);
      chk("reset_id_ready", {180'd0, id_ready}, 181'd0);
      #3 reset = 1'b0;
      @(posedge clock);
      #1;
      chk("ready_after_reset", {180'd0, id_ready}, 181'd1);

      step(1'b0, 32'h0, 32'h0, 1'b1, 5'd3, 32'h5, BUBBLE, "wb_r3");
      step(1'b1, 32'h100, 32'h00630820, 1'b0, 5'd0, 32'h0,
           mk(1, 1, 4'h0, 5'd1, 5'd3, 5'd3, 32'h00630820, 32'h100, 32'h5, 32'h5, 32'h820), "add_r1_r3_r3");
      step(1'b1, 32'h104, 32'h2002FFFC, 1'b0, 5'd0, 32'h0,
           mk(1, 1, 4'h0, 5'd2, 5'd2, 5'd0, 32'h2002FFFC, 32'h104, 32'h0, 32'h0, 32'hFFFFFFFC), "addi_neg4");
      step(1'b1, 32'h108, 32'h00E04025, 1'b1, 5'd7, 32'hDEAD,
           mk(1, 1, 4'h3, 5'd8, 5'd0, 5'd7, 32'h00E04025, 32'h108, 32'hDEAD, 32'h0, 32'h4025), "or_bypass_r7");
      step(1'b1, 32'h10C, 32'h00074825, 1'b1, 5'd0, 32'h1234,
           mk(1, 1, 4'h3, 5'd9, 5'd7, 5'd0, 32'h00074825, 32'h10C, 32'h0, 32'hDEAD, 32'h4825), "or_r0_write_ignored");
      step(1'b1, 32'h110, 32'hFC000000, 1'b0, 5'd0, 32'h0,
           mk(1, 0, 4'hF, 5'd0, 5'd0, 5'd0, 32'hFC000000, 32'h110, 32'h0, 32'h0, 32'h0), "illegal_opcode");
      step(1'b0, 32'h114, 32'h00630820, 1'b0, 5'd0, 32'h0, BUBBLE, "if_valid_low_bubble");
      step(1'b1, 32'h118, 32'h0000303F, 1'b0, 5'd0, 32'h0,
           mk(1, 0, 4'hF, 5'd0, 5'd0, 5'd0, 32'h0000303F, 32'h118, 32'h0, 32'h0, 32'h303F), "illegal_funct");
      step(1'b1, 32'h11C, 32'hAC030004, 1'b0, 5'd0, 32'h0,
           mk(1, 0, 4'h0, 5'd0, 5'd3, 5'd0, 32'hAC030004, 32'h11C, 32'h0, 32'h5, 32'h4), "sw");
      step(1'b1, 32'h120, 32'h10220003, 1'b0, 5'd0, 32'h0,
           mk(1, 0, 4'h1, 5'd0, 5'd2, 5'd1, 32'h10220003, 32'h120, 32'h0, 32'h0, 32'h3), "beq");
      step(1'b1, 32'h124, 32'h20000001, 1'b0, 5'd0, 32'h0,
           mk(1, 0, 4'h0, 5'd0, 5'd0, 5'd0, 32'h20000001, 32'h124, 32'h0, 32'h0, 32'h1), "addi_rd0_no_write");

      // Load-use: LW r4 then ADD r5, r4, r4
      step(1'b1, 32'h128, 32'h8C040000, 1'b0, 5'd0, 32'h0,
           mk(1, 1, 4'h0, 5'd4, 5'd4, 5'd0, 32'h8C040000, 32'h128, 32'h0, 32'h0, 32'h0), "lw_r4");
`ifdef DECODE_HAZARD_EN
      drive(1'b1, 32'h12C, 32'h00842820, 1'b0, 5'd0, 32'h0);
      #1;
      chk("hazard_ready_low", {180'd0, id_ready}, 181'd0);
      step(1'b1, 32'h12C, 32'h00842820, 1'b0, 5'd0, 32'h0, BUBBLE, "hazard_bubble");
`endif
      drive(1'b1, 32'h12C, 32'h00842820, 1'b1, 5'd4, 32'h77);
      #1;
      chk("add_after_lw_ready", {180'd0, id_ready}, 181'd1);
      step(1'b1, 32'h12C, 32'h00842820, 1'b1, 5'd4, 32'h77,
           mk(1, 1, 4'h0, 5'd5, 5'd4, 5'd4, 32'h00842820, 32'h12C, 32'h77, 32'h77, 32'h2820), "add_after_lw");

      // Load followed by an idle slot: no stall on the next dependent instruction
      step(1'b1, 32'h130, 32'h8C060000, 1'b0, 5'd0, 32'h0,
           mk(1, 1, 4'h0, 5'd6, 5'd6, 5'd0, 32'h8C060000, 32'h130, 32'h0, 32'h0, 32'h0), "lw_r6");
      step(1'b0, 32'h134, 32'h00C62820, 1'b0, 5'd0, 32'h0, BUBBLE, "lw_then_idle");
      step(1'b1, 32'h134, 32'h00C62820, 1'b0, 5'd0, 32'h0,
           mk(1, 1, 4'h0, 5'd5, 5'd6, 5'd6, 32'h00C62820, 32'h134, 32'h0, 32'h0, 32'h2820), "add_after_idle");

      // Reset mid-operation clears the bundle and the register file
      step(1'b1, 32'h140, 32'h00630820, 1'b0, 5'd0, 32'h0,
           mk(1, 1, 4'h0, 5'd1, 5'd3, 5'd3, 32'h00630820, 32'h140, 32'h5, 32'h5, 32'h820), "add_before_reset");
      @(negedge clock);
      #1 reset = 1'b1;
      #1;
      chk("midreset_id_ex", ID_EX, BUBBLE);
      chk("midreset_id_ready", {180'd0, id_ready}, 181'd0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      step(1'b1, 32'h144, 32'h00630820, 1'b0, 5'd0, 32'h0,
           mk(1, 1, 4'h0, 5'd1, 5'd3, 5'd3, 32'h00630820, 32'h144, 32'h0, 32'h0, 32'h820), "add_regs_cleared");
      step(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, BUBBLE, "final_bubble");

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
      @(negedge clock);
      #1;
      if (q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expected entries never checked", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
